// File: rtl/seg_scan_ctrl_if.sv
// Handshake/display bundle for seg_scan_ctrl: load request in, load ack,
// shared decoder code, active-low anodes and frame pulse out.
interface seg_scan_ctrl_if #(
   parameter int NUM_DIGITS = 4
);
   logic                      load;
   logic [4*NUM_DIGITS-1:0]   value;
   logic                      load_ack;
   logic [3:0]                dig;
   logic [NUM_DIGITS-1:0]     an;
   logic                      frame_done;

   modport master (
      output load, value,
      input  load_ack, dig, an, frame_done
   );

   modport slave (
      input  load, value,
      output load_ack, dig, an, frame_done
   );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for common-anode 7-segment digits with a
// blank guard gap per slot and frame-synchronous value updates.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LZB_EN.
module seg_scan_ctrl #(
   parameter int NUM_DIGITS   = 4,
   parameter int BLANK_CYCLES = 4,
   parameter int SHOW_CYCLES  = 1000
) (
   input  logic              clk,
   input  logic              rst,
   seg_scan_ctrl_if.slave    bus
);

   localparam int MAXC  = (BLANK_CYCLES > SHOW_CYCLES) ? BLANK_CYCLES : SHOW_CYCLES;
   localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int VW    = 4 * NUM_DIGITS;

   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

   typedef enum logic {ST_BLANK, ST_SHOW} state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [VW-1:0]       disp_q, disp_d;
   logic [VW-1:0]       pend_q, pend_d;
   logic                pend_v_q, pend_v_d;
   logic [NUM_DIGITS-1:0] an_q, an_d;
   logic [3:0]          dig_q, dig_d;
   logic                ack_q, ack_d;
   logic                fd_q, fd_d;
   logic                boundary;
   logic                hide;

   function automatic logic [3:0] nibble(input logic [VW-1:0] v, input logic [IDX_W-1:0] i);
      nibble = 4'hF;
      for (int k = 0; k < NUM_DIGITS; k++)
         if (IDX_W'(k) == i) nibble = v[4*k +: 4];
   endfunction

   function automatic logic [NUM_DIGITS-1:0] an_mask(input logic [IDX_W-1:0] i);
      an_mask = '1;
      for (int k = 0; k < NUM_DIGITS; k++)
         if (IDX_W'(k) == i) an_mask[k] = 1'b0;
   endfunction

`ifdef SEG_SCAN_LZB_EN
   // A digit is hidden only when it and every more significant digit are zero.
   function automatic logic lz_hidden(input logic [VW-1:0] v, input logic [IDX_W-1:0] i);
      lz_hidden = (i != '0);
      for (int k = 0; k < NUM_DIGITS; k++)
         if (k >= int'(i) && v[4*k +: 4] != 4'd0) lz_hidden = 1'b0;
   endfunction
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      disp_d   = disp_q;
      pend_d   = pend_q;
      pend_v_d = pend_v_q;
      ack_d    = 1'b0;
      boundary = 1'b0;
      an_d     = '1;
      dig_d    = 4'hF;
      hide     = 1'b0;

      case (state_q)
         ST_BLANK: begin
            if (cnt_q == BLANK_LAST) begin
               state_d = ST_SHOW;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_SHOW: begin
            if (cnt_q == SHOW_LAST) begin
               state_d  = ST_BLANK;
               cnt_d    = '0;
               boundary = (idx_q == IDX_LAST);
               idx_d    = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = ST_BLANK;
      endcase

      if (bus.load) begin
         pend_d   = bus.value;
         pend_v_d = 1'b1;
      end

      // A load on the boundary cycle itself goes straight to the display.
      if (boundary && (bus.load || pend_v_q)) begin
         disp_d   = bus.load ? bus.value : pend_q;
         pend_v_d = 1'b0;
         ack_d    = 1'b1;
      end

      fd_d = boundary;

`ifdef SEG_SCAN_LZB_EN
      hide = lz_hidden(disp_d, idx_d);
`else
      hide = 1'b0;
`endif

      // Outputs are registered from next-state so they track the state entered.
      if (state_d == ST_SHOW && !hide) begin
         an_d  = an_mask(idx_d);
         dig_d = nibble(disp_d, idx_d);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_BLANK;
         cnt_q    <= '0;
         idx_q    <= '0;
         disp_q   <= '0;
         pend_q   <= '0;
         pend_v_q <= 1'b0;
         an_q     <= '1;
         dig_q    <= 4'hF;
         ack_q    <= 1'b0;
         fd_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         disp_q   <= disp_d;
         pend_q   <= pend_d;
         pend_v_q <= pend_v_d;
         an_q     <= an_d;
         dig_q    <= dig_d;
         ack_q    <= ack_d;
         fd_q     <= fd_d;
      end
   end

   assign bus.an         = an_q;
   assign bus.dig        = dig_q;
   assign bus.load_ack   = ack_q;
   assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: a cycle-count based reference model
// predicts anode, digit, frame_done and load_ack for every cycle.
module tb_seg_scan_ctrl;

   localparam int N     = 4;
   localparam int B     = 2;
   localparam int S     = 3;
   localparam int SLOT  = B + S;
   localparam int FRAME = N * SLOT;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   seg_scan_ctrl_if #(.NUM_DIGITS(N)) bus ();

   seg_scan_ctrl #(
      .NUM_DIGITS  (N),
      .BLANK_CYCLES(B),
      .SHOW_CYCLES (S)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model: t is the cycle number since reset release (1 = first).
   int          t = 0;
   logic [15:0] m_disp = '0;
   logic [15:0] m_pend = '0;
   logic        m_pv   = 1'b0;
   logic [N-1:0] exp_an  = '1;
   logic [3:0]  exp_dig  = 4'hF;
   logic        exp_fd   = 1'b0;
   logic        exp_ack  = 1'b0;

   function automatic int cur_pos();
      return (t - 1) % FRAME;
   endfunction

   task automatic step(input logic r, input logic ld, input logic [15:0] v);
      int p, slot, w;
      logic bnd, hide;
      rst       = r;
      bus.load  = ld;
      bus.value = v;
      bnd = (t >= 1) && (cur_pos() == FRAME - 1);
      if (r) begin
         t = 1; m_disp = '0; m_pend = '0; m_pv = 1'b0;
         exp_ack = 1'b0; exp_fd = 1'b0;
      end else begin
         if (ld) begin m_pend = v; m_pv = 1'b1; end
         exp_ack = 1'b0;
         if (bnd && m_pv) begin m_disp = m_pend; m_pv = 1'b0; exp_ack = 1'b1; end
         exp_fd = bnd;
         t++;
      end
      @(posedge clk);
      #1;
      p = cur_pos(); slot = p / SLOT; w = p % SLOT;
      exp_an = '1; exp_dig = 4'hF; hide = 1'b0;
`ifdef SEG_SCAN_LZB_EN
      if (slot > 0 && (m_disp >> (4 * slot)) == 16'd0) hide = 1'b1;
`endif
      if (w >= B && !hide) begin
         exp_an[slot] = 1'b0;
         exp_dig = m_disp[4*slot +: 4];
      end
   endtask

   task automatic test_reset();
      bus.load = 1'b0; bus.value = '0;
      step(1, 0, 16'h0);
      step(1, 0, 16'h0);
      checks++;
      if ({bus.an, bus.dig, bus.load_ack, bus.frame_done} !== {4'b1111, 4'hF, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL reset an=%b dig=%h ack=%b fd=%b required an=1111 dig=f ack=0 fd=0",
                  bus.an, bus.dig, bus.load_ack, bus.frame_done);
      end
   endtask

   task automatic test_idle_scan();
      int fd_seen[$];
      for (int i = 0; i < 41; i++) begin
         step(0, 0, 16'h0);
         checks++;
         if ({bus.an, bus.dig, bus.frame_done, bus.load_ack} !== {exp_an, exp_dig, exp_fd, exp_ack}) begin
            failures++;
            $display("FAIL idle t=%0d an=%b dig=%h fd=%b ack=%b required an=%b dig=%h fd=%b ack=%b",
                     t, bus.an, bus.dig, bus.frame_done, bus.load_ack, exp_an, exp_dig, exp_fd, exp_ack);
         end
         if (bus.frame_done === 1'b1) fd_seen.push_back(t);
      end
      checks++;
      if (fd_seen.size() != 2 || fd_seen[0] != 21 || fd_seen[1] != 41) begin
         failures++;
         $display("FAIL idle_fd_cycles count=%0d first=%0d required 2 pulses at 21 and 41",
                  fd_seen.size(), (fd_seen.size() > 0) ? fd_seen[0] : -1);
      end
   endtask

   task automatic test_load_midframe();
      while (cur_pos() != 7) step(0, 0, 16'h0);
      step(0, 1, 16'h1234);
      for (int i = 0; i < 45; i++) begin
         step(0, 0, 16'hFFFF);
         checks++;
         if ({bus.an, bus.dig, bus.frame_done, bus.load_ack} !== {exp_an, exp_dig, exp_fd, exp_ack}) begin
            failures++;
            $display("FAIL load_mid t=%0d an=%b dig=%h fd=%b ack=%b required an=%b dig=%h fd=%b ack=%b",
                     t, bus.an, bus.dig, bus.frame_done, bus.load_ack, exp_an, exp_dig, exp_fd, exp_ack);
         end
      end
   endtask

   task automatic test_double_load();
      int acks = 0;
      while (cur_pos() != 3) step(0, 0, 16'h0);
      step(0, 1, 16'h1111);
      step(0, 0, 16'h0);
      step(0, 1, 16'h5678);
      for (int i = 0; i < 40; i++) begin
         step(0, 0, 16'h0);
         checks++;
         if ({bus.an, bus.dig, bus.frame_done, bus.load_ack} !== {exp_an, exp_dig, exp_fd, exp_ack}) begin
            failures++;
            $display("FAIL double_load t=%0d an=%b dig=%h fd=%b ack=%b required an=%b dig=%h fd=%b ack=%b",
                     t, bus.an, bus.dig, bus.frame_done, bus.load_ack, exp_an, exp_dig, exp_fd, exp_ack);
         end
         if (bus.load_ack === 1'b1) acks++;
      end
      checks++;
      if (acks != 1) begin
         failures++;
         $display("FAIL double_load_acks got=%0d required=1", acks);
      end
   endtask

   task automatic test_boundary_load();
      int acks = 0;
      while (cur_pos() != FRAME - 1) step(0, 0, 16'h0);
      step(0, 1, 16'h9999);
      checks++;
      if ({bus.load_ack, bus.frame_done} !== 2'b11) begin
         failures++;
         $display("FAIL boundary_ack ack=%b fd=%b required ack=1 fd=1", bus.load_ack, bus.frame_done);
      end
      for (int i = 0; i < 30; i++) begin
         step(0, 0, 16'h0);
         checks++;
         if ({bus.an, bus.dig, bus.frame_done, bus.load_ack} !== {exp_an, exp_dig, exp_fd, exp_ack}) begin
            failures++;
            $display("FAIL boundary_load t=%0d an=%b dig=%h fd=%b ack=%b required an=%b dig=%h fd=%b ack=%b",
                     t, bus.an, bus.dig, bus.frame_done, bus.load_ack, exp_an, exp_dig, exp_fd, exp_ack);
         end
         if (bus.load_ack === 1'b1) acks++;
      end
      checks++;
      if (acks != 0) begin
         failures++;
         $display("FAIL boundary_second_ack got=%0d required=0", acks);
      end
   endtask

   task automatic test_reset_midframe();
      while (cur_pos() != 0) step(0, 0, 16'h0);
      step(0, 1, 16'h4321);
      while (cur_pos() != 2 * SLOT + B) step(0, 0, 16'h0);
      step(1, 0, 16'h0);
      checks++;
      if ({bus.an, bus.dig, bus.load_ack, bus.frame_done} !== {4'b1111, 4'hF, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL reset_mid an=%b dig=%h ack=%b fd=%b required an=1111 dig=f ack=0 fd=0",
                  bus.an, bus.dig, bus.load_ack, bus.frame_done);
      end
      for (int i = 0; i < 45; i++) begin
         step(0, 0, 16'h0);
         checks++;
         if ({bus.an, bus.dig, bus.frame_done, bus.load_ack} !== {exp_an, exp_dig, exp_fd, exp_ack}) begin
            failures++;
            $display("FAIL reset_mid_scan t=%0d an=%b dig=%h fd=%b ack=%b required an=%b dig=%h fd=%b ack=%b",
                     t, bus.an, bus.dig, bus.frame_done, bus.load_ack, exp_an, exp_dig, exp_fd, exp_ack);
         end
      end
   endtask

   task automatic test_leading_zeros();
      logic [15:0] vals [3];
      vals[0] = 16'h0042; vals[1] = 16'h0000; vals[2] = 16'h0500;
      for (int k = 0; k < 3; k++) begin
         while (cur_pos() != 5) step(0, 0, 16'h0);
         step(0, 1, vals[k]);
         for (int i = 0; i < 40; i++) begin
            step(0, 0, 16'h0);
            checks++;
            if ({bus.an, bus.dig, bus.frame_done, bus.load_ack} !== {exp_an, exp_dig, exp_fd, exp_ack}) begin
               failures++;
               $display("FAIL lzb v=%h t=%0d an=%b dig=%h fd=%b ack=%b required an=%b dig=%h fd=%b ack=%b",
                        vals[k], t, bus.an, bus.dig, bus.frame_done, bus.load_ack, exp_an, exp_dig, exp_fd, exp_ack);
            end
         end
      end
   endtask

   task automatic test_random();
      logic r, ld;
      logic [15:0] v;
      for (int i = 0; i < 600; i++) begin
         r  = ($urandom_range(0, 149) == 0);
         ld = ($urandom_range(0, 6) == 0);
         v  = 16'($urandom);
         step(r, ld, v);
         checks++;
         if ({bus.an, bus.dig, bus.frame_done, bus.load_ack} !== {exp_an, exp_dig, exp_fd, exp_ack}) begin
            failures++;
            $display("FAIL random t=%0d an=%b dig=%h fd=%b ack=%b required an=%b dig=%h fd=%b ack=%b",
                     t, bus.an, bus.dig, bus.frame_done, bus.load_ack, exp_an, exp_dig, exp_fd, exp_ack);
         end
      end
   endtask

   initial begin
      test_reset();
      test_idle_scan();
      test_load_midframe();
      test_double_load();
      test_boundary_load();
      test_reset_midframe();
      test_leading_zeros();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
